// File: rtl/sd_read_sched_if.sv
// Request/response and SPI byte-engine bundle for the SD single-block read scheduler.
// The scheduler takes the slave side; requesters, the byte engine and the data sink take the master side.
interface sd_read_sched_if;
    logic        init_done;
    logic        sdhc;
    logic [1:0]  req;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        xfer_req;
    logic [7:0]  xfer_tx;
    logic        xfer_ack;
    logic [7:0]  xfer_rx;
    logic        sd_cs;
    logic        data_valid;
    logic [7:0]  data_byte;
    logic        data_last;
    logic        data_owner;

    modport slave (
        input  init_done, sdhc, req, addr0, addr1, xfer_ack, xfer_rx,
        output done, err, xfer_req, xfer_tx, sd_cs, data_valid, data_byte, data_last, data_owner
    );

    modport master (
        output init_done, sdhc, req, addr0, addr1, xfer_ack, xfer_rx,
        input  done, err, xfer_req, xfer_tx, sd_cs, data_valid, data_byte, data_last, data_owner
    );
endinterface

// File: rtl/sd_read_sched.sv
// Two-requester SD card CMD17 (single block read) scheduler with round-robin arbitration.
// Issues the command, polls R1 and the start token, streams 512 payload bytes, then releases the card.
module sd_read_sched #(
    parameter int unsigned R1_POLL_MAX    = 8,
    parameter int unsigned TOKEN_POLL_MAX = 4096
) (
    input  logic           clk,
    input  logic           rst_n,
    sd_read_sched_if.slave sd_io
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_R1    = 3'd2;
    localparam logic [2:0] S_TOKEN = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_CRC   = 3'd5;
    localparam logic [2:0] S_TAIL  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam int unsigned POLL_MAX = (TOKEN_POLL_MAX > R1_POLL_MAX) ? TOKEN_POLL_MAX : R1_POLL_MAX;
    localparam int unsigned CNT_W    = $clog2(((POLL_MAX > 512) ? POLL_MAX : 512) + 1);

    localparam logic [CNT_W-1:0] R1_LIMIT  = CNT_W'(R1_POLL_MAX);
    localparam logic [CNT_W-1:0] TOK_LIMIT = CNT_W'(TOKEN_POLL_MAX);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(5);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(511);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      arg_q, arg_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [1:0]       code_q, code_d;
    logic             cs_q, cs_d;
    logic             xreq_q, xreq_d;
    logic [7:0]       xtx_q, xtx_d;
    logic [1:0]       done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic             dv_q, dv_d;
    logic             dlast_q, dlast_d;
    logic [7:0]       dbyte_q, dbyte_d;

    logic             grant_pick;
    logic [31:0]      sel_addr;
    logic             byte_done;
    logic [7:0]       tx_byte;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        tx_byte = 8'hFF;
        if (state_q == S_CMD) begin
            case (cnt_q[2:0])
                3'd0:    tx_byte = 8'h51;
                3'd1:    tx_byte = arg_q[31:24];
                3'd2:    tx_byte = arg_q[23:16];
                3'd3:    tx_byte = arg_q[15:8];
                3'd4:    tx_byte = arg_q[7:0];
                default: tx_byte = 8'hFF;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arg_d     = arg_q;
        owner_d   = owner_q;
        last_d    = last_q;
        code_d    = code_q;
        cs_d      = cs_q;
        xreq_d    = xreq_q;
        xtx_d     = xtx_q;
        done_d    = '0;
        err_d     = '0;
        dv_d      = 1'b0;
        dlast_d   = 1'b0;
        dbyte_d   = dbyte_q;
        byte_done = 1'b0;

        grant_pick = (sd_io.req == 2'b11) ? ~last_q : sd_io.req[1];
        sel_addr   = grant_pick ? sd_io.addr1 : sd_io.addr0;

        // Byte engine: request raised only from a low request register, so every transfer is separated by an idle cycle.
        if (state_q != S_IDLE && state_q != S_DONE) begin
            if (!xreq_q) begin
                xreq_d = 1'b1;
                xtx_d  = tx_byte;
            end else if (sd_io.xfer_ack) begin
                xreq_d    = 1'b0;
                byte_done = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (sd_io.init_done && sd_io.req != 2'b00) begin
                    owner_d = grant_pick;
                    last_d  = grant_pick;
                    arg_d   = sd_io.sdhc ? sel_addr : {sel_addr[22:0], 9'd0};
                    cs_d    = 1'b0;
                    cnt_d   = '0;
                    code_d  = '0;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (byte_done) begin
                    if (cnt_q == CMD_LAST) begin
                        cnt_d   = '0;
                        state_d = S_R1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_R1: begin
                if (byte_done) begin
                    if (!sd_io.xfer_rx[7]) begin
                        cnt_d = '0;
                        if (sd_io.xfer_rx == 8'h00) begin
                            state_d = S_TOKEN;
                        end else begin
                            code_d  = 2'd2;
                            cs_d    = 1'b1;
                            state_d = S_TAIL;
                        end
                    end else if (cnt_inc == R1_LIMIT) begin
                        code_d  = 2'd1;
                        cs_d    = 1'b1;
                        state_d = S_TAIL;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_TOKEN: begin
                if (byte_done) begin
                    if (sd_io.xfer_rx == 8'hFE) begin
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end else if (sd_io.xfer_rx == 8'hFF && cnt_inc != TOK_LIMIT) begin
                        cnt_d = cnt_inc;
                    end else begin
                        code_d  = 2'd3;
                        cs_d    = 1'b1;
                        state_d = S_TAIL;
                    end
                end
            end
            S_DATA: begin
                if (byte_done) begin
                    dv_d    = 1'b1;
                    dbyte_d = sd_io.xfer_rx;
                    dlast_d = (cnt_q == DATA_LAST);
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = S_CRC;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_CRC: begin
                if (byte_done) begin
                    if (cnt_q == CRC_LAST) begin
                        cs_d    = 1'b1;
                        state_d = S_TAIL;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_TAIL: begin
                if (byte_done) begin
                    done_d  = owner_q ? 2'b10 : 2'b01;
                    err_d   = code_q;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            arg_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            code_q  <= '0;
            cs_q    <= 1'b1;
            xreq_q  <= 1'b0;
            xtx_q   <= 8'hFF;
            done_q  <= '0;
            err_q   <= '0;
            dv_q    <= 1'b0;
            dlast_q <= 1'b0;
            dbyte_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            arg_q   <= arg_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            code_q  <= code_d;
            cs_q    <= cs_d;
            xreq_q  <= xreq_d;
            xtx_q   <= xtx_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
            dlast_q <= dlast_d;
            dbyte_q <= dbyte_d;
        end
    end

    assign sd_io.sd_cs      = cs_q;
    assign sd_io.xfer_req   = xreq_q;
    assign sd_io.xfer_tx    = xtx_q;
    assign sd_io.done       = done_q;
    assign sd_io.err        = err_q;
    assign sd_io.data_valid = dv_q;
    assign sd_io.data_byte  = dbyte_q;
    assign sd_io.data_last  = dlast_q;
    assign sd_io.data_owner = owner_q;
endmodule

// File: tb/tb_sd_read_sched.sv
// Bench for sd_read_sched: scripted SD card model on the byte engine, outcome predicted from the
// card script (poll counts, error code, payload) and compared against what the scheduler produced.
module tb_sd_read_sched;
    localparam int unsigned R1MAX  = 8;
    localparam int unsigned TOKMAX = 16;

    logic clk;
    logic rst_n;
    sd_read_sched_if bus ();

    sd_read_sched #(.R1_POLL_MAX(R1MAX), .TOKEN_POLL_MAX(TOKMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sd_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0]  resp[$];
    logic [7:0]  data_exp[$];
    logic [7:0]  rx_data[$];
    logic [7:0]  cmd_log[$];
    int unsigned low_cnt;
    int unsigned tail_cnt;
    int unsigned last_cnt;
    logic        last_served;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Card model: answers each byte after a random latency; idles 0xFF while deselected or out of script.
    initial begin
        bit          busy;
        logic [7:0]  held_tx;
        int unsigned wait_cnt;
        busy = 0; held_tx = 8'hFF; wait_cnt = 0;
        bus.xfer_ack = 1'b0;
        bus.xfer_rx  = 8'hFF;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.xfer_ack = 1'b0;
                busy = 0;
            end else if (bus.xfer_ack) begin
                bus.xfer_ack = 1'b0;
                check("req_gap", bus.xfer_req, 1'b0);
            end else if (bus.xfer_req) begin
                if (!busy) begin
                    busy     = 1;
                    held_tx  = bus.xfer_tx;
                    wait_cnt = $urandom_range(0, 2);
                end else begin
                    check("tx_stable", bus.xfer_tx, held_tx);
                end
                if (wait_cnt == 0) begin
                    busy = 0;
                    if (bus.sd_cs) begin
                        tail_cnt++;
                        check("tail_tx", bus.xfer_tx, 8'hFF);
                        bus.xfer_rx = 8'hFF;
                    end else if (cmd_log.size() < 6) begin
                        low_cnt++;
                        cmd_log.push_back(bus.xfer_tx);
                        bus.xfer_rx = 8'hFF;
                    end else begin
                        low_cnt++;
                        check("poll_tx", bus.xfer_tx, 8'hFF);
                        bus.xfer_rx = (resp.size() > 0) ? resp.pop_front() : 8'hFF;
                    end
                    bus.xfer_ack = 1'b1;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.data_valid) begin
                rx_data.push_back(bus.data_byte);
                if (bus.data_last) last_cnt++;
                check("data_last", bus.data_last, rx_data.size() == 512);
            end
        end
    end

    task automatic load_card(input int unsigned r1_delay, input logic [7:0] r1_val,
                             input int unsigned tok_delay, input logic [7:0] tok_val, input bit ramp);
        resp.delete(); data_exp.delete(); rx_data.delete(); cmd_log.delete();
        low_cnt = 0; tail_cnt = 0; last_cnt = 0;
        if (r1_delay < R1MAX) begin
            repeat (r1_delay) resp.push_back(8'hFF);
            resp.push_back(r1_val);
            if (r1_val == 8'h00 && tok_delay < TOKMAX) begin
                repeat (tok_delay) resp.push_back(8'hFF);
                resp.push_back(tok_val);
                if (tok_val == 8'hFE) begin
                    for (int i = 0; i < 512; i++) begin
                        logic [7:0] b;
                        b = ramp ? 8'(i) : 8'($urandom);
                        data_exp.push_back(b);
                        resp.push_back(b);
                    end
                    repeat (2) resp.push_back(8'($urandom));
                end
            end
        end
    endtask

    task automatic run_txn(input string tag, input logic [1:0] reqmask, input logic sdhc_v,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input int unsigned r1_delay, input logic [7:0] r1_val,
                           input int unsigned tok_delay, input logic [7:0] tok_val,
                           input bit ramp, input bit drop_mid);
        logic        exp_owner;
        logic [31:0] arg;
        logic [1:0]  exp_err;
        int unsigned r1_polls, tok_polls, ndata, bad, n;
        logic [1:0]  d, e;
        logic        o;
        logic [47:0] cmd_got;

        exp_owner = (reqmask == 2'b11) ? !last_served : reqmask[1];
        arg = exp_owner ? a1 : a0;
        if (!sdhc_v) arg = arg * 32'd512;
        tok_polls = 0; ndata = 0;
        if (r1_delay >= R1MAX) begin
            exp_err = 2'd1; r1_polls = R1MAX;
        end else begin
            r1_polls = r1_delay + 1;
            if (r1_val != 8'h00) exp_err = 2'd2;
            else if (tok_delay >= TOKMAX) begin exp_err = 2'd3; tok_polls = TOKMAX; end
            else begin
                tok_polls = tok_delay + 1;
                if (tok_val == 8'hFE) begin exp_err = 2'd0; ndata = 512; end
                else exp_err = 2'd3;
            end
        end

        load_card(r1_delay, r1_val, tok_delay, tok_val, ramp);
        bus.addr0 = a0; bus.addr1 = a1; bus.sdhc = sdhc_v; bus.req = reqmask;
        if (drop_mid) begin
            repeat (4) @(negedge clk);
            bus.req = 2'b00;
            bus.init_done = 1'b0;
        end

        d = '0; e = '0; o = 1'b0; n = 0;
        while (n < 20000) begin
            @(negedge clk);
            if (bus.done != 2'b00) begin d = bus.done; e = bus.err; o = bus.data_owner; break; end
            n++;
        end
        bus.req = 2'b00;
        bus.init_done = 1'b1;
        last_served = exp_owner;

        check({tag, "_done"}, d, exp_owner ? 2'b10 : 2'b01);
        check({tag, "_err"}, e, exp_err);
        check({tag, "_owner"}, o, exp_owner);
        @(negedge clk);
        check({tag, "_done_1cyc"}, bus.done, 2'b00);
        repeat (2) @(negedge clk);
        check({tag, "_cs_idle"}, bus.sd_cs, 1'b1);
        check({tag, "_cmd_len"}, cmd_log.size(), 6);
        cmd_got = '0;
        if (cmd_log.size() == 6) for (int i = 0; i < 6; i++) cmd_got = {cmd_got[39:0], cmd_log[i]};
        check({tag, "_cmd"}, cmd_got, {8'h51, arg, 8'hFF});
        check({tag, "_cs_bytes"}, low_cnt, 6 + r1_polls + tok_polls + ((ndata != 0) ? 514 : 0));
        check({tag, "_tail"}, tail_cnt, 1);
        check({tag, "_ndata"}, rx_data.size(), ndata);
        bad = 0;
        for (int i = 0; i < rx_data.size() && i < data_exp.size(); i++)
            if (rx_data[i] !== data_exp[i]) bad++;
        check({tag, "_payload"}, bad, 0);
        check({tag, "_nlast"}, last_cnt, (ndata != 0) ? 1 : 0);
    endtask

    initial begin
        int unsigned n;
        bit seen_done, seen_req;
        logic [1:0] m;

        rst_n = 1'b0;
        bus.init_done = 1'b0; bus.sdhc = 1'b1; bus.req = 2'b00;
        bus.addr0 = '0; bus.addr1 = '0;
        last_served = 1'b1;
        low_cnt = 0; tail_cnt = 0; last_cnt = 0;
        repeat (2) @(negedge clk);
        check("rst_cs", bus.sd_cs, 1'b1);
        check("rst_xreq", bus.xfer_req, 1'b0);
        check("rst_xtx", bus.xfer_tx, 8'hFF);
        check("rst_done_err", {bus.done, bus.err}, 4'b0000);
        check("rst_data", {bus.data_valid, bus.data_byte, bus.data_last}, 10'd0);
        check("rst_owner", bus.data_owner, 1'b0);
        rst_n = 1'b1;

        // No grant while the card is not initialised.
        bus.req = 2'b01;
        seen_req = 0;
        repeat (10) begin @(negedge clk); if (bus.xfer_req || !bus.sd_cs) seen_req = 1; end
        check("no_init_grant", seen_req, 1'b0);
        bus.req = 2'b00;
        bus.init_done = 1'b1;
        @(negedge clk);

        run_txn("basic",     2'b01, 1'b1, 32'd5, 32'($urandom), 2, 8'h00, 3, 8'hFE, 1'b1, 1'b0);
        run_txn("sdsc",      2'b10, 1'b0, 32'($urandom), 32'd3, 1, 8'h00, 0, 8'hFE, 1'b0, 1'b0);
        run_txn("r1_tmo",    2'b01, 1'b1, 32'd7, 32'd9, 100, 8'h00, 0, 8'hFE, 1'b0, 1'b0);
        run_txn("err_tok",   2'b01, 1'b1, 32'd8, 32'd9, 0, 8'h00, 1, 8'h08, 1'b0, 1'b0);
        run_txn("r1_nz",     2'b10, 1'b1, 32'd8, 32'd9, 1, 8'h04, 0, 8'hFE, 1'b0, 1'b0);
        run_txn("tok_tmo",   2'b01, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 8'h00, TOKMAX, 8'hFE, 1'b0, 1'b0);
        run_txn("r1_last",   2'b01, 1'b1, 32'd2, 32'd1, R1MAX - 1, 8'h04, 0, 8'hFE, 1'b0, 1'b0);
        run_txn("tok_last",  2'b10, 1'b1, 32'd2, 32'hDEAD_BEEF, 0, 8'h00, TOKMAX - 1, 8'hFE, 1'b0, 1'b0);
        run_txn("drop_mid",  2'b01, 1'b0, 32'h0080_0001, 32'd4, 0, 8'h00, 2, 8'hFE, 1'b0, 1'b1);

        for (int k = 0; k < 4; k++) begin
            m = 2'($urandom_range(1, 3));
            run_txn("rand", m, 1'($urandom), 32'($urandom), 32'($urandom),
                    $urandom_range(0, 9),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 127)) : 8'h00,
                    $urandom_range(0, 18),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 253)) : 8'hFE,
                    1'b0, 1'b0);
        end

        // Reset in the middle of the payload abandons the read.
        load_card(1, 8'h00, 1, 8'hFE, 1'b0);
        bus.sdhc = 1'b1; bus.addr0 = 32'($urandom); bus.req = 2'b01;
        n = 0;
        while (rx_data.size() < 100 && n < 20000) begin @(negedge clk); n++; end
        check("rst_mid_reach", rx_data.size(), 100);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_cs", bus.sd_cs, 1'b1);
        check("rst_mid_xreq", bus.xfer_req, 1'b0);
        check("rst_mid_dv", bus.data_valid, 1'b0);
        bus.req = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        resp.delete();
        last_served = 1'b1;
        seen_done = 0; seen_req = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done != 2'b00) seen_done = 1;
            if (bus.xfer_req) seen_req = 1;
        end
        check("rst_mid_no_done", seen_done, 1'b0);
        check("rst_mid_idle", seen_req, 1'b0);
        check("rst_mid_cs_idle", bus.sd_cs, 1'b1);

        // Simultaneous requests after reset alternate starting with requester 0.
        for (int k = 0; k < 3; k++)
            run_txn("rr", 2'b11, 1'b1, 32'd10, 32'd20, 0, 8'h04, 0, 8'hFE, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sd_read_sched.md
SD_READ_SCHED -- requirements
Module: sd_read_sched

Interface
REQ-001 Parameter R1_POLL_MAX, default 8, meaning max 0xFF poll bytes while waiting for R1.
REQ-002 Parameter TOKEN_POLL_MAX, default 4096, meaning max poll bytes while waiting for the start token 0xFE.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 init_done  input  1  card initialised; no arbitration while low.
REQ-006 sdhc  input  1  1 = block addressing, 0 = SDSC byte addressing.
REQ-007 req  input  2  per-requester read request, level, held until matching done.
REQ-008 addr0, addr1  input  32 each  block number for requester 0 and 1.
REQ-009 done  output  2  one-cycle completion pulse per requester.
REQ-010 err  output  2  error code, valid with done: 0 ok, 1 R1 timeout, 2 R1 nonzero, 3 token timeout or error token.
REQ-011 xfer_req  output  1  byte-transfer request to the SPI byte engine.
REQ-012 xfer_tx  output  8  byte to shift out.
REQ-013 xfer_ack  input  1  one-cycle pulse: transfer finished.
REQ-014 xfer_rx  input  8  received byte, valid with xfer_ack.
REQ-015 sd_cs  output  1  card chip select, active-low.
REQ-016 data_valid  output  1  one-cycle pulse per payload byte.
REQ-017 data_byte  output  8  payload byte.
REQ-018 data_last  output  1  high with the 512th data_valid.
REQ-019 data_owner  output  1  index of the requester being served.

Function
REQ-020 States: IDLE, CMD, R1, TOKEN, DATA, CRC, TAIL, DONE.
REQ-021 Byte handshake: xfer_req and xfer_tx stay stable from assertion until the cycle of xfer_ack; xfer_req deasserts for at least one cycle between transfers.
REQ-022 IDLE: when init_done=1 and req!=0, grant one requester. Round-robin: on simultaneous requests, grant the requester other than the last served. After reset, requester 0 wins a tie.
REQ-023 Grant: latch the requester's address. If sdhc=0, arg = addr<<9 truncated to 32 bits; otherwise arg = addr. Set data_owner, drive sd_cs=0, go to CMD.
REQ-024 CMD: send 6 bytes: 0x51, arg[31:24], arg[23:16], arg[15:8], arg[7:0], 0xFF.
REQ-025 R1: send 0xFF until xfer_rx[7]=0. If R1=0x00, go to TOKEN. If R1 is any other value with bit 7 clear, err=2 and go to TAIL. If R1_POLL_MAX bytes pass without a response, err=1 and go to TAIL.
REQ-026 TOKEN: send 0xFF. Received 0xFE -> go to DATA. Received 0xFF -> keep polling. Any other value -> err=3, go to TAIL. TOKEN_POLL_MAX bytes without a token -> err=3, go to TAIL.
REQ-027 DATA: send 0xFF 512 times. Each xfer_ack produces data_valid=1 with data_byte=xfer_rx in the next cycle; data_last marks byte 512. There is no backpressure.
REQ-028 CRC: send 0xFF twice and discard the received CRC bytes.
REQ-029 TAIL: drive sd_cs=1, then send one 0xFF byte.
REQ-030 DONE: pulse done[owner] for one cycle with err, then return to IDLE. The next grant happens no earlier than the following cycle.
REQ-031 A requester that deasserts req mid-transaction does not abort it; done is still pulsed.
REQ-032 If init_done falls mid-transaction, the transaction completes. Only new grants are blocked.
REQ-033 Poll and byte counters are wide enough that they never wrap before their limit.

Reset
REQ-034 rst_n=0 immediately forces: state IDLE, sd_cs=1, xfer_req=0, xfer_tx=0xFF, done=0, err=0, data_valid=0, data_byte=0, data_last=0, data_owner=0, last-served = 1.
REQ-035 Reset asserted mid-transaction abandons it; no done pulse is issued for it after reset release.

Verification
REQ-036 req=01, addr0=5, sdhc=1, card model returns R1 0x00 after 2 polls, token after 3 polls, then bytes 0..255,0..255 -> command bytes 51 00 00 00 05 FF; 512 data_valid with matching data; data_last on the 512th; done=01, err=0.
REQ-037 sdhc=0, addr1=3, req=10 -> argument bytes 00 00 06 00; data_owner=1; done=10.
REQ-038 req=11 in the same cycle, three times back-to-back after reset -> serve order 0, 1, 0.
REQ-039 Card never answers (always 0xFF) -> exactly 8 R1 polls, then sd_cs=1, one tail byte, done with err=1, no data_valid.
REQ-040 Card returns R1 0x00 then error token 0x08 -> err=3. Separately, R1 0x04 -> err=2. Neither case produces data_valid.
REQ-041 rst_n pulsed low during DATA byte 100 -> sd_cs=1 and xfer_req=0 in the same cycle; after release, state IDLE and no done pulse.
